weight_loader: RTL and testbench

Runtime-writable weight store for the accelerator datapath. It accepts a byte stream over a valid/ready handshake and assembles little-endian `ByteWidth`-byte words. Each word is written to an internal `2**AddrWidth`-entry memory at an auto-incrementing address. A synchronous read port with 1-cycle latency lets the compute datapath read weights after a software-driven load, instead of using weights fixed at synthesis.

---
 rtl/weight_loader_if.sv | 26 ++
 rtl/weight_loader.sv | 151 +++++++++++++++
 tb/tb_weight_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/weight_loader_if.sv
// Byte-stream load handshake plus weight read port of weight_loader.
// slave = loader side, master = stream source / compute datapath side.
interface weight_loader_if #(
  parameter int ByteWidth = 12,
  parameter int AddrWidth = 6
);
  logic                   start;
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   busy;
  logic                   done;
  logic                   cksum_err;
  logic [AddrWidth-1:0]   addr;
  logic [ByteWidth*8-1:0] dout;

  modport slave (
    input  start, in_data, in_valid, addr,
    output in_ready, busy, done, cksum_err, dout
  );

  modport master (
    output start, in_data, in_valid, addr,
    input  in_ready, busy, done, cksum_err, dout
  );
endinterface

// File: rtl/weight_loader.sv
// Runtime-writable weight store: assembles little-endian words from a byte stream into
// an auto-addressed memory; 1-cycle registered read. Optional trailing checksum: WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int ByteWidth = 12,
  parameter int AddrWidth = 6
) (
  input  logic           clk,
  input  logic           rstn,
  weight_loader_if.slave wl
);
  localparam int WordW = ByteWidth * 8;
  localparam int HoldW = (ByteWidth - 1) * 8;
  localparam int Depth = 2 ** AddrWidth;
  localparam int BcntW = $clog2(ByteWidth);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    S_CKSUM,
`endif
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] waddr_q, waddr_d;
  logic [BcntW-1:0]     bcnt_q, bcnt_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic [WordW-1:0]     dout_q;
  logic                 we;
  logic [WordW-1:0]     wdata;
  logic                 accept;
  logic [WordW-1:0]     mem [Depth];

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    bcnt_d  = bcnt_q;
    hold_d  = hold_q;
    we      = 1'b0;
    wdata   = {wl.in_data, hold_q};
    accept  = wl.in_valid & active_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    // start wins over a same-cycle handshake; that byte and any partial word are dropped
    if (wl.start) begin
      state_d = S_LOAD;
      waddr_d = '0;
      bcnt_d  = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            sum_d = sum_q + wl.in_data;
`endif
            if (bcnt_q == BcntW'(ByteWidth - 1)) begin
              we      = 1'b1;
              bcnt_d  = '0;
              waddr_d = waddr_q + AddrWidth'(1);
              if (waddr_q == {AddrWidth{1'b1}}) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                state_d = S_CKSUM;
`else
                state_d = S_DONE;
`endif
              end
            end else begin
              for (int k = 0; k < ByteWidth - 1; k++) begin
                if (bcnt_q == BcntW'(k)) hold_d[8*k +: 8] = wl.in_data;
              end
              bcnt_d = bcnt_q + BcntW'(1);
            end
          end
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        S_CKSUM: begin
          if (accept) begin
            sum_d   = sum_q + wl.in_data;
            err_d   = (sum_d != 8'd0);
            state_d = S_DONE;
          end
        end
`endif
        default: ;
      endcase
    end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    active_d = (state_d == S_LOAD) || (state_d == S_CKSUM);
`else
    active_d = (state_d == S_LOAD);
`endif
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      waddr_q  <= '0;
      bcnt_q   <= '0;
      hold_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      bcnt_q   <= bcnt_d;
      hold_q   <= hold_d;
      active_q <= active_d;
      done_q   <= done_d;
      dout_q   <= mem[wl.addr];
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
      err_q    <= err_d;
`endif
    end
  end

  // Non-blocking write beside the registered read gives read-before-write on collision
  always_ff @(posedge clk) begin
    if (rstn && we) mem[waddr_q] <= wdata;
  end

  assign wl.in_ready = active_q;
  assign wl.busy     = active_q;
  assign wl.done     = done_q;
  assign wl.dout     = dout_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  assign wl.cksum_err = err_q;
`else
  assign wl.cksum_err = 1'b0;
`endif
endmodule

// File: tb/tb_weight_loader.sv
// Directed load sequences with randomized stream gaps, checked against a memory-image model.
module tb_weight_loader;
  localparam int BW = 12;
  localparam int AW = 6;
  localparam int NW = 2 ** AW;
  localparam int NB = BW * NW;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CKSUM_ON = 1'b1;
`else
  localparam bit CKSUM_ON = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  weight_loader_if #(.ByteWidth(BW), .AddrWidth(AW)) bus ();
  weight_loader #(.ByteWidth(BW), .AddrWidth(AW)) dut (.clk(clk), .rstn(rstn), .wl(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit watch_busy = 1'b0;
  int busy_drops = 0;
  logic [BW*8-1:0] model [NW];

  task automatic check(input string tag, input logic [BW*8-1:0] obs, input logic [BW*8-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int mode, input int i);
    case (mode)
      0:       return 8'(i % 256);
      1:       return 8'hA5;
      2:       return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (watch_busy && bus.busy !== 1'b1 && bus.done !== 1'b1) busy_drops++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int wait_n = 0;
    repeat (gap) step();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && wait_n < 50) begin
      step();
      wait_n++;
    end
    if (wait_n >= 50) check("ready_timeout", 0, 1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit with_byte);
    bus.start = 1'b1;
    if (with_byte) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
    end
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("start_in_ready", bus.in_ready, 1);
    check("start_busy", bus.busy, 1);
    check("start_done", bus.done, 0);
    check("start_cksum_err", bus.cksum_err, 0);
  endtask

  task automatic load_full(input int mode, input int gapmax, input int cks_delta, input bit collide);
    logic [7:0] b;
    logic [7:0] sum = 8'd0;
    for (int i = 0; i < NB; i++) begin
      b = byte_of(mode, i);
      sum += b;
      model[i / BW][(i % BW) * 8 +: 8] = b;
      if (i == NB - 1) check("done_before_last", bus.done, 0);
      send_byte(b, (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
      if (collide && i == BW - 1) begin
        check("collide_old", bus.dout, '0);
        step();
        check("collide_new", bus.dout, {BW{8'hFF}});
      end
    end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    check("cksum_wait_ready", bus.in_ready, 1);
    check("cksum_wait_done", bus.done, 0);
    send_byte(8'(8'd0 - sum) + 8'(cks_delta), 0);
`endif
    check("done_after_last", bus.done, 1);
    check("busy_after_last", bus.busy, 0);
    check("ready_after_last", bus.in_ready, 0);
    check("cksum_err", bus.cksum_err, (CKSUM_ON && cks_delta != 0) ? 1 : 0);
  endtask

  task automatic read_all(input string tag);
    for (int w = 0; w < NW; w++) begin
      bus.addr = AW'(w);
      step();
      check(tag, bus.dout, model[w]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    bus.addr     = '0;
    rstn         = 1'b0;
    step();
    step();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cksum_err", bus.cksum_err, 0);
    check("rst_dout", bus.dout, '0);
    rstn         = 1'b1;
    bus.in_valid = 1'b0;
    step();
    check("idle_busy", bus.busy, 0);
    check("idle_in_ready", bus.in_ready, 0);

    // Full load, incrementing pattern
    pulse_start(1'b0);
    load_full(0, 0, 0, 1'b0);
    bus.addr = '0;
    step();
    check("addr0_const", bus.dout, 96'h0B0A09080706050403020100);
    bus.addr = AW'(NW - 1);
    step();
    check("addr63_const", bus.dout, 96'hFFFEFDFCFBFAF9F8F7F6F5F4);
    read_all("full_img");

    // Restart after 5 bytes of word 3, with a byte offered on the start cycle
    pulse_start(1'b0);
    for (int i = 0; i < 3 * BW + 5; i++) send_byte(8'(i + 7), 0);
    pulse_start(1'b1);
    load_full(1, 0, 0, 1'b0);
    read_all("restart_img");

    // Backpressure with random gaps
    pulse_start(1'b0);
    watch_busy = 1'b1;
    load_full(0, 5, 0, 1'b0);
    watch_busy = 1'b0;
    check("busy_held", busy_drops, 0);
    read_all("gap_img");

    // Zero image, then collision on word 0 while loading all-ones
    pulse_start(1'b0);
    load_full(2, 0, 0, 1'b0);
    bus.addr = '0;
    pulse_start(1'b0);
    load_full(3, 0, 1, 1'b1);
    read_all("ones_img");

    pulse_start(1'b0);
    check("restart_clears_done", bus.done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
